icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Miss-refill and flush sequencer for the instruction cache. Accepts one line-miss request at a time and fetches the line from memory as a sequence of single-beat reads. It then writes the complete line into the cache array with the valid bit and tag set. It also sweeps the array on a flush request, clearing every valid bit; the cache's fetch path stalls while this block is busy.

Parameters:
NFU, 2, functional units per bundle; line data = NFU*32 bits
NCACHE_ENTRIES, 256, cache lines; CACHEINDEX = clog2(NCACHE_ENTRIES)
PHYSICAL_ADDRESS_LENGTH, 56, physical address width
MEM_DATA_WIDTH, 32, memory read beat width; must divide NFU*32; BEATS = NFU*32/MEM_DATA_WIDTH
(derived) CACHELINEINDEX = clog2(NFU*4), TAGSIZE = PHYSICAL_ADDRESS_LENGTH-CACHEINDEX-CACHELINEINDEX, LINEW = NFU*32+1+TAGSIZE

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
missValid  in  1  cache reports a miss
missAddress  in  PHYSICAL_ADDRESS_LENGTH  missing fetch address
missReady  out  1  miss accepted when missValid&&missReady
flushReq  in  1  request invalidate-all (level, sampled each cycle)
flushDone  out  1  one-cycle pulse after final invalidate write
memReqValid  out  1  memory read request valid
memReqReady  in  1  memory accepts request
memReqAddress  out  PHYSICAL_ADDRESS_LENGTH  beat-aligned read address
memRespValid  in  1  read data valid
memRespData  in  MEM_DATA_WIDTH  read data
memRespError  in  1  bus error, qualified by memRespValid
cacheWrEn  out  1  write strobe to cache array
cacheWrIndex  out  CACHEINDEX  line index to write
cacheWrLine  out  LINEW  {valid, tag, data}; valid is MSB, then tag, data in low NFU*32 bits
refillDone  out  1  one-cycle pulse, refill finished (success or error)
refillError  out  1  one-cycle pulse with refillDone when aborted

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except missReady=0. Beat counter, flush index and pending-flush flag cleared. Reset mid-refill or mid-flush abandons the operation with no further cache writes.
- States: IDLE, REQ, RESP, WRITE, FLUSH.
- IDLE:
  - missReady=1 unless flushReq or a pending flush is set.
  - Flush has priority over a simultaneous miss: go to FLUSH with index 0.
  - On an accepted miss: latch lineBase = missAddress with low CACHELINEINDEX bits zeroed, latch cacheIndex/tag fields, beat=0, go to REQ.
- REQ: memReqValid=1, memReqAddress = lineBase + beat*(MEM_DATA_WIDTH/8). Held stable until memReqReady; then go to RESP.
- RESP: wait for memRespValid (responses outside RESP are ignored).
  - Error: discard the line, no cache write, pulse refillDone and refillError, go to IDLE.
  - Otherwise store the beat into data bits [beat*W +: W] (beat 0 = least significant).
  - If beat==BEATS-1 go to WRITE, else beat+1 and go to REQ.
- WRITE:
  - Exactly one cycle: cacheWrEn=1, cacheWrIndex = latched index, cacheWrLine = {1'b1, tag, data}, refillDone=1.
  - Next state is FLUSH (index 0) if a flush is pending, else IDLE.
- flushReq seen outside IDLE/FLUSH sets the pending flag, serviced after the current refill ends (success or error). flushReq during FLUSH is absorbed.
- FLUSH:
  - One write per cycle: cacheWrEn=1, cacheWrIndex=index, cacheWrLine=0.
  - Index increments; on index NCACHE_ENTRIES-1, pulse flushDone in that same cycle and go to IDLE. Index wraps to 0; no overflow past the last entry.
  - Pending flag is cleared on entry to FLUSH.
- Timing, with memReqReady=1 and response one cycle after request:
  - Accept at cycle 0; beat k requested at cycle 1+2k; WRITE/refillDone at cycle 2*BEATS+1.
  - For default parameters this is cycle 5.
- Flush takes NCACHE_ENTRIES cycles of cacheWrEn plus one entry cycle.
- Outputs are registered (Moore) except missReady, which is combinational from state, flushReq and the pending flag.

Test Plan:
- Reset, then miss at 0x0000_0000_0010_0A4C: memReqAddress 0x...100A48 then 0x...100A4C. Responses 0x11111111, 0x22222222 -> cycle 5: cacheWrEn=1, cacheWrIndex=0x49, cacheWrLine data=0x2222222211111111, valid=1, tag=address>>11; refillDone pulse.
- memReqReady held 0 for 4 cycles on beat 0 -> memReqValid and address stable throughout, no extra requests; WRITE delayed by 4 cycles.
- memRespError=1 on beat 1 -> no cacheWrEn, refillDone=refillError=1 for one cycle; missReady=1 next cycle.
- flushReq and missValid in same IDLE cycle -> missReady=0, 256 consecutive writes of 0 to indices 0..255, flushDone with index 255; then miss accepted.
- flushReq pulsed during RESP -> refill completes normally, FLUSH starts in the cycle after WRITE.
- rst_n low mid-FLUSH at index 100 -> outputs 0 immediately, no further writes, IDLE after release.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill and invalidate-all sequencer.
// A missing line is fetched as single-beat reads, then written once as {valid, tag, data}.
module icache_refill_ctrl #(
    parameter int NFU                     = 2,
    parameter int NCACHE_ENTRIES          = 256,
    parameter int PHYSICAL_ADDRESS_LENGTH = 56,
    parameter int MEM_DATA_WIDTH          = 32,
    localparam int CACHEINDEX     = $clog2(NCACHE_ENTRIES),
    localparam int CACHELINEINDEX = $clog2(NFU * 4),
    localparam int TAGSIZE        = PHYSICAL_ADDRESS_LENGTH - CACHEINDEX - CACHELINEINDEX,
    localparam int DATAW          = NFU * 32,
    localparam int LINEW          = DATAW + 1 + TAGSIZE
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               missValid,
    input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] missAddress,
    output logic                               missReady,
    input  logic                               flushReq,
    output logic                               flushDone,
    output logic                               memReqValid,
    input  logic                               memReqReady,
    output logic [PHYSICAL_ADDRESS_LENGTH-1:0] memReqAddress,
    input  logic                               memRespValid,
    input  logic [MEM_DATA_WIDTH-1:0]          memRespData,
    input  logic                               memRespError,
    output logic                               cacheWrEn,
    output logic [CACHEINDEX-1:0]              cacheWrIndex,
    output logic [LINEW-1:0]                   cacheWrLine,
    output logic                               refillDone,
    output logic                               refillError
);

    localparam int PAL        = PHYSICAL_ADDRESS_LENGTH;
    localparam int BEATS      = DATAW / MEM_DATA_WIDTH;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BYTES = MEM_DATA_WIDTH / 8;
    localparam logic [PAL-1:0]        LINE_MASK  = ~PAL'(NFU * 4 - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [CACHEINDEX-1:0] LAST_ENTRY = CACHEINDEX'(NCACHE_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        WRITE,
        FLUSH
    } state_t;

    state_t                  state, state_nxt;
    logic [BEAT_W-1:0]       beat, beat_nxt;
    logic [CACHEINDEX-1:0]   flush_idx, flush_idx_nxt;
    logic                    flush_pend, flush_pend_nxt;
    logic                    err_q, err_nxt;
    logic                    load_miss, store_beat;
    logic [PAL-1:0]          line_base;
    logic [DATAW-1:0]        line_data;
    logic [TAGSIZE-1:0]      line_tag;
    logic [CACHEINDEX-1:0]   line_index;

    // Tag and index are fields of the latched line base; its low bits are always zero.
    assign line_tag   = line_base[PAL-1 -: TAGSIZE];
    assign line_index = line_base[CACHELINEINDEX +: CACHEINDEX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            flush_idx  <= '0;
            flush_pend <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            flush_idx  <= flush_idx_nxt;
            flush_pend <= flush_pend_nxt;
            err_q      <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (load_miss) begin
            line_base <= missAddress & LINE_MASK;
        end
        if (store_beat) begin
            line_data[int'(beat) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= memRespData;
        end
    end

    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        flush_idx_nxt  = flush_idx;
        flush_pend_nxt = flush_pend;
        err_nxt        = 1'b0;
        load_miss      = 1'b0;
        store_beat     = 1'b0;
        missReady      = 1'b0;
        memReqValid    = 1'b0;
        memReqAddress  = '0;
        cacheWrEn      = 1'b0;
        cacheWrIndex   = '0;
        cacheWrLine    = '0;
        flushDone      = 1'b0;

        // A flush requested mid-refill waits until the refill has finished.
        if (flushReq && state != IDLE && state != FLUSH) begin
            flush_pend_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                missReady = rst_n && !(flushReq || flush_pend);
                if (flushReq || flush_pend) begin
                    state_nxt      = FLUSH;
                    flush_idx_nxt  = '0;
                    flush_pend_nxt = 1'b0;
                end else if (missValid) begin
                    load_miss = 1'b1;
                    beat_nxt  = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                memReqValid   = 1'b1;
                memReqAddress = line_base + (PAL'(beat) * PAL'(BEAT_BYTES));
                if (memReqReady) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (memRespValid) begin
                    if (memRespError) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        store_beat = 1'b1;
                        if (beat == LAST_BEAT) begin
                            state_nxt = WRITE;
                        end else begin
                            beat_nxt  = beat + BEAT_W'(1);
                            state_nxt = REQ;
                        end
                    end
                end
            end
            WRITE: begin
                cacheWrEn    = 1'b1;
                cacheWrIndex = line_index;
                cacheWrLine  = {1'b1, line_tag, line_data};
                if (flush_pend || flushReq) begin
                    state_nxt      = FLUSH;
                    flush_idx_nxt  = '0;
                    flush_pend_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                cacheWrEn    = 1'b1;
                cacheWrIndex = flush_idx;
                if (flush_idx == LAST_ENTRY) begin
                    flushDone     = 1'b1;
                    flush_idx_nxt = '0;
                    state_nxt     = IDLE;
                end else begin
                    flush_idx_nxt = flush_idx + CACHEINDEX'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // An aborted refill reports from IDLE in the cycle after the failing beat.
    assign refillDone  = (state == WRITE) || err_q;
    assign refillError = err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench: a memory responder and write monitor check the DUT against queued expectations.
module tb_icache_refill_ctrl;

    localparam int PAL   = 56;
    localparam int CIW   = 8;
    localparam int LINEW = 110;
    localparam int NENT  = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             missValid;
    logic [PAL-1:0]   missAddress;
    logic             missReady;
    logic             flushReq;
    logic             flushDone;
    logic             memReqValid;
    logic             memReqReady;
    logic [PAL-1:0]   memReqAddress;
    logic             memRespValid;
    logic [31:0]      memRespData;
    logic             memRespError;
    logic             cacheWrEn;
    logic [CIW-1:0]   cacheWrIndex;
    logic [LINEW-1:0] cacheWrLine;
    logic             refillDone;
    logic             refillError;

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .missValid    (missValid),
        .missAddress  (missAddress),
        .missReady    (missReady),
        .flushReq     (flushReq),
        .flushDone    (flushDone),
        .memReqValid  (memReqValid),
        .memReqReady  (memReqReady),
        .memReqAddress(memReqAddress),
        .memRespValid (memRespValid),
        .memRespData  (memRespData),
        .memRespError (memRespError),
        .cacheWrEn    (cacheWrEn),
        .cacheWrIndex (cacheWrIndex),
        .cacheWrLine  (cacheWrLine),
        .refillDone   (refillDone),
        .refillError  (refillError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CIW-1:0]   idx;
        logic [LINEW-1:0] line;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    wr_t            wr_q[$];
    rsp_t           rsp_q[$];
    logic [PAL-1:0] addr_q[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int stall_cycles = 0;
    logic resp_pend = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: one-cycle response latency, optional ready stall on the next request.
    always @(negedge clk) begin
        memRespValid = 1'b0;
        memRespError = 1'b0;
        memRespData  = '0;
        if (!rst_n) begin
            memReqReady = 1'b0;
            resp_pend   = 1'b0;
        end else begin
            if (resp_pend) begin
                resp_pend = 1'b0;
                if (rsp_q.size() > 0) begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    memRespValid = 1'b1;
                    memRespData  = r.data;
                    memRespError = r.err;
                end
            end
            if (memReqValid) begin
                if (addr_q.size() == 0) begin
                    memReqReady = 1'b0;
                    check("extra_request", memReqValid, 1'b0);
                end else if (stall_cycles > 0) begin
                    memReqReady = 1'b0;
                    stall_cycles--;
                    check("req_addr_stable", memReqAddress, addr_q[0]);
                end else begin
                    logic [PAL-1:0] ea;
                    memReqReady = 1'b1;
                    ea = addr_q.pop_front();
                    check("req_addr", memReqAddress, ea);
                    resp_pend = 1'b1;
                end
            end else begin
                memReqReady = 1'b0;
            end
        end
    end

    // Every cache write must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && cacheWrEn) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", cacheWrEn, 1'b0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_index", cacheWrIndex, e.idx);
                check("wr_line", cacheWrLine, e.line);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_refill(input logic [PAL-1:0] addr, input logic [31:0] d0,
                               input logic [31:0] d1, input int err_beat);
        logic [PAL-1:0]   base;
        logic [31:0]      d[2];
        wr_t              w;
        base = addr & ~56'h7;
        d[0] = d0;
        d[1] = d1;
        for (int k = 0; k < 2; k++) begin
            addr_q.push_back(base + 56'(k * 4));
            rsp_q.push_back('{data: d[k], err: (k == err_beat)});
            if (k == err_beat) break;
        end
        if (err_beat < 0) begin
            w.idx  = CIW'(addr >> 3);
            w.line = {1'b1, 45'(addr >> 11), d1, d0};
            wr_q.push_back(w);
        end
    endtask

    task automatic push_flush();
        for (int i = 0; i < NENT; i++) begin
            wr_q.push_back('{idx: CIW'(i), line: '0});
        end
    endtask

    // Entered at the negedge of the first cycle after acceptance.
    task automatic finish_refill(input int start, input int exp_lat, input logic exp_err);
        int cnt;
        cnt = start;
        while (!refillDone && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("refill_latency", cnt, exp_lat);
        check("refill_error", refillError, exp_err);
    endtask

    task automatic do_miss(input logic [PAL-1:0] addr, input int exp_lat, input logic exp_err);
        missValid   = 1'b1;
        missAddress = addr;
        #1;
        check("miss_ready", missReady, 1'b1);
        @(negedge clk);
        missValid = 1'b0;
        finish_refill(1, exp_lat, exp_err);
    endtask

    task automatic wait_flush_done(input int exp_cycles);
        int cnt;
        cnt = 1;
        while (!flushDone && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("flush_cycles", cnt, exp_cycles);
        check("flush_last_index", cacheWrIndex, 8'hFF);
    endtask

    initial begin
        logic [31:0] r0, r1;
        int cnt;
        rst_n        = 1'b0;
        missValid    = 1'b0;
        missAddress  = '0;
        flushReq     = 1'b0;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRespData  = '0;
        memRespError = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miss_ready", missReady, 1'b0);
        check("rst_mem_req", memReqValid, 1'b0);
        check("rst_wr_en", cacheWrEn, 1'b0);
        check("rst_wr_line", cacheWrLine, '0);
        check("rst_refill_done", refillDone, 1'b0);
        check("rst_flush_done", flushDone, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_miss_ready", missReady, 1'b1);

        // Basic refill of the reference address.
        push_refill(56'h10_0A4C, 32'h1111_1111, 32'h2222_2222, -1);
        do_miss(56'h10_0A4C, 5, 1'b0);
        @(negedge clk);

        // Memory holds off the first request for four cycles.
        r0 = $urandom;
        r1 = $urandom;
        stall_cycles = 4;
        push_refill(56'hAB_CDEF_0123_4567, r0, r1, -1);
        do_miss(56'hAB_CDEF_0123_4567, 9, 1'b0);
        @(negedge clk);

        // Bus error on the second beat aborts without a write.
        push_refill(56'h12_3456_789A_BCD8, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1);
        do_miss(56'h12_3456_789A_BCD8, 5, 1'b1);
        @(negedge clk);
        check("err_pulse_one_cycle", refillDone, 1'b0);
        check("err_then_ready", missReady, 1'b1);

        // Simultaneous flush and miss: flush first, then the miss.
        r0 = $urandom;
        r1 = $urandom;
        push_flush();
        push_refill(56'h00_0000_0FFF_FFF0, r0, r1, -1);
        flushReq    = 1'b1;
        missValid   = 1'b1;
        missAddress = 56'h00_0000_0FFF_FFF0;
        #1;
        check("flush_blocks_miss", missReady, 1'b0);
        @(negedge clk);
        flushReq = 1'b0;
        check("flushing_not_ready", missReady, 1'b0);
        wait_flush_done(256);
        @(negedge clk);
        check("post_flush_ready", missReady, 1'b1);
        @(negedge clk);
        missValid = 1'b0;
        finish_refill(1, 5, 1'b0);
        @(negedge clk);

        // Flush requested while a refill waits on its response.
        push_refill(56'h55_AAAA_5555_0000, 32'h0BAD_CAFE, 32'h1357_9BDF, -1);
        push_flush();
        missValid   = 1'b1;
        missAddress = 56'h55_AAAA_5555_0000;
        @(negedge clk);
        missValid = 1'b0;
        @(negedge clk);
        check("resp_no_req", memReqValid, 1'b0);
        flushReq = 1'b1;
        @(negedge clk);
        flushReq = 1'b0;
        finish_refill(3, 5, 1'b0);
        @(negedge clk);
        check("pend_flush_start", cacheWrEn, 1'b1);
        check("pend_flush_idx0", cacheWrIndex, 8'h00);
        wait_flush_done(256);
        @(negedge clk);
        check("pend_flush_idle", missReady, 1'b1);

        // Reset in the middle of a flush.
        push_flush();
        flushReq = 1'b1;
        @(negedge clk);
        flushReq = 1'b0;
        cnt = 1;
        while (cacheWrIndex != 8'd100 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("flush_reach_100", cnt, 101);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", cacheWrEn, 1'b0);
        check("mid_rst_index", cacheWrIndex, 8'h00);
        check("mid_rst_flush_done", flushDone, 1'b0);
        check("mid_rst_miss_ready", missReady, 1'b0);
        wr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_write", cacheWrEn, 1'b0);
        end
        check("post_rst_ready", missReady, 1'b1);

        // Normal refill after reset recovery.
        push_refill(56'h10_0A4C, 32'hA5A5_A5A5, 32'h5A5A_5A5A, -1);
        do_miss(56'h10_0A4C, 5, 1'b0);
        repeat (3) @(negedge clk);
        check("leftover_writes", wr_q.size(), 0);
        check("leftover_requests", addr_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
